// File: rtl/ysyx_mem_arb_pkg.sv
// Shared encodings for the IFU/LSU read arbiter: FSM states, owner IDs, response codes.
package ysyx_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_arb_pick.sv
// Owner selection between IFU and LSU; ptr_i names the requester that wins a tie.
module ysyx_arb_pick
    import ysyx_mem_arb_pkg::*;
(
    input  logic ifu_req_i,
    input  logic lsu_req_i,
    input  logic ptr_i,
    output logic own_o
);

    always_comb begin
        own_o = OWN_LSU;
        if (ifu_req_i && lsu_req_i) begin
            own_o = ptr_i;
        end else if (ifu_req_i) begin
            own_o = OWN_IFU;
        end
    end

endmodule

// File: rtl/ysyx_mem_arb.sv
// Two-requester (IFU/LSU) read arbiter in front of a single AXI-like read port.
// Define YSYX_MEM_ARB_RR_EN for round-robin ties; otherwise the LSU always wins a tie.
module ysyx_mem_arb
    import ysyx_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    output logic              ifu_rerr,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    output logic              lsu_rerr,

    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready
);

    arb_state_e        state_q;
    logic              own_q;
    logic [ADDR_W-1:0] addr_q;
    logic              arvalid_q;
    logic              rready_q;

    logic              pick_own;
    logic              tie_ptr;
    logic [ADDR_W-1:0] grant_addr_d;
    logic              rsp_fire;

`ifdef YSYX_MEM_ARB_RR_EN
    logic ptr_q;
    assign tie_ptr = ptr_q;
`else
    assign tie_ptr = OWN_LSU;
`endif

    ysyx_arb_pick u_pick (
        .ifu_req_i (ifu_arvalid),
        .lsu_req_i (lsu_arvalid),
        .ptr_i     (tie_ptr),
        .own_o     (pick_own)
    );

    assign grant_addr_d = (pick_own == OWN_LSU) ? lsu_araddr : ifu_araddr;

    // Requests are only looked at in IDLE; a grant is never revoked once taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            own_q     <= OWN_LSU;
            addr_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`ifdef YSYX_MEM_ARB_RR_EN
            ptr_q     <= OWN_LSU;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ifu_arvalid || lsu_arvalid) begin
                        own_q     <= pick_own;
                        addr_q    <= grant_addr_d;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mem_rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
`ifdef YSYX_MEM_ARB_RR_EN
                        ptr_q    <= ~own_q;
`endif
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_arvalid = arvalid_q;
    assign mem_araddr  = arvalid_q ? addr_q : '0;
    assign mem_rready  = rready_q;

    // rready_q is only high in DATA, so stray beats in IDLE/ADDR never fire.
    assign rsp_fire   = rready_q & mem_rvalid;
    assign ifu_rvalid = rsp_fire & (own_q == OWN_IFU);
    assign lsu_rvalid = rsp_fire & (own_q == OWN_LSU);

    assign ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    assign ifu_rerr   = ifu_rvalid & resp_is_err(mem_rresp);
    assign lsu_rerr   = lsu_rvalid & resp_is_err(mem_rresp);

endmodule

// File: tb/tb_ysyx_mem_arb.sv
// Scoreboard bench for ysyx_mem_arb: a memory responder with programmable delays plus a response monitor.
module tb_ysyx_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, mem_araddr;
    logic        ifu_arvalid, lsu_arvalid, mem_arvalid;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic        ifu_rvalid, lsu_rvalid, ifu_rerr, lsu_rerr;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_rdata   = '0;
    logic [1:0]  mem_rresp   = '0;
    logic        mem_rvalid  = 1'b0;
    logic        mem_rready;

    always #5 clk = ~clk;

    ysyx_mem_arb dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_araddr  (ifu_araddr),
        .ifu_arvalid (ifu_arvalid),
        .ifu_rdata   (ifu_rdata),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rerr    (ifu_rerr),
        .lsu_araddr  (lsu_araddr),
        .lsu_arvalid (lsu_arvalid),
        .lsu_rdata   (lsu_rdata),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rerr    (lsu_rerr),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready)
    );

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ar_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          ar_dly = 0;
    int          r_dly  = 0;
    logic [1:0]  resp_cfg = 2'b00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_1234);
    endfunction

    task automatic expect_rd(input bit lsu, input logic [31:0] a);
        exp_t e;
        e.lsu  = lsu;
        e.data = memfn(a);
        e.err  = (resp_cfg != 2'b00);
        sb.push_back(e);
        ar_q.push_back(a);
    endtask

    // Waits for the named requester's rvalid, then returns just after the next rising edge.
    task automatic wait_rv(input bit lsu, input int max, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max) begin
            @(negedge clk);
            cyc++;
            got = lsu ? lsu_rvalid : ifu_rvalid;
        end
        if (!got) chk("wait_rv_timeout", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        sb.delete();
        ar_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Memory model: accepts one address, then returns one beat after the programmed delays.
    always begin : responder
        logic [31:0] a;
        bit          aborted;
        int          k;
        @(posedge clk); #1;
        if (mem_arvalid) begin
            a = mem_araddr;
            if (ar_q.size() == 0) chk("ar_unexpected", mem_arvalid, 0);
            else chk("ar_order", a, ar_q.pop_front());
            repeat (ar_dly) begin
                @(posedge clk); #1;
                chk("ar_hold", {mem_arvalid, mem_araddr}, {1'b1, a});
            end
            mem_arready = 1'b1;
            @(posedge clk); #1;
            mem_arready = 1'b0;
            chk("rready_on", mem_rready, 1);
            aborted = 1'b0;
            k = 0;
            while (k < r_dly && !aborted) begin
                @(posedge clk); #1;
                if (rst) aborted = 1'b1;
                else chk("rready_hold", mem_rready, 1);
                k++;
            end
            if (aborted) begin
                while (rst) begin @(posedge clk); #1; end
                // late beat from the abandoned transaction
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
                mem_rresp  = 2'b10;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = memfn(a);
                mem_rresp  = resp_cfg;
            end
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_rresp  = '0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (ifu_rvalid || lsu_rvalid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {ifu_rvalid, lsu_rvalid}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", {ifu_rvalid, lsu_rvalid}, e.lsu ? 2'b01 : 2'b10);
                    chk("rsp_data", e.lsu ? lsu_rdata : ifu_rdata, e.data);
                    chk("rsp_err", e.lsu ? lsu_rerr : ifu_rerr, e.err);
                    chk("rsp_other", e.lsu ? {ifu_rerr, ifu_rdata} : {lsu_rerr, lsu_rdata}, 0);
                end
            end else begin
                chk("quiet", |{ifu_rdata, lsu_rdata, ifu_rerr, lsu_rerr}, 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int          cyc;
        bit          got, wl, own, fav;
        logic [31:0] la, ia;

        rst = 1'b1;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        lsu_araddr  = 32'h8000_1000;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {mem_arvalid, mem_rready, ifu_rvalid, lsu_rvalid, ifu_rerr, lsu_rerr}, 0);
        chk("rst_addr", mem_araddr, 0);
        chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // IFU-only read, minimum latency
        ifu_araddr = 32'h8000_0000;
        expect_rd(0, 32'h8000_0000);
        ifu_arvalid = 1'b1;
        wait_rv(0, 20, cyc);
        ifu_arvalid = 1'b0;
        chk("ifu_latency", cyc, 3);
        settle(3);

        // LSU read with error response
        resp_cfg = 2'b10;
        lsu_araddr = 32'h8000_1008;
        expect_rd(1, 32'h8000_1008);
        lsu_arvalid = 1'b1;
        wait_rv(1, 20, cyc);
        lsu_arvalid = 1'b0;
        chk("lsu_latency", cyc, 3);
        resp_cfg = 2'b00;
        settle(3);

        // simultaneous requests straight after reset: LSU first
        do_reset();
        ifu_araddr = 32'h8000_0004;
        lsu_araddr = 32'h8000_1000;
        expect_rd(1, 32'h8000_1000);
        expect_rd(0, 32'h8000_0004);
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        wait_rv(1, 20, cyc);
        lsu_arvalid = 1'b0;
        wait_rv(0, 20, cyc);
        ifu_arvalid = 1'b0;
        chk("second_grant_latency", cyc, 3);
        settle(3);

        // slow memory: arready after 5 cycles, rvalid after 7 more
        ar_dly = 5;
        r_dly  = 7;
        ifu_araddr = 32'h8000_0040;
        expect_rd(0, 32'h8000_0040);
        ifu_arvalid = 1'b1;
        wait_rv(0, 40, cyc);
        ifu_arvalid = 1'b0;
        chk("slow_latency", cyc, 15);
        r_dly = 0;
        settle(3);

        // granted request completes even after arvalid drops
        ar_dly = 3;
        ifu_araddr = 32'h8000_0100;
        expect_rd(0, 32'h8000_0100);
        ifu_arvalid = 1'b1;
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        wait_rv(0, 20, cyc);
        settle(3);

        // IFU pulse while LSU owns the port is never served
        lsu_araddr = 32'h8000_1100;
        expect_rd(1, 32'h8000_1100);
        lsu_arvalid = 1'b1;
        @(posedge clk); #1;
        ifu_araddr  = 32'h8000_0180;
        ifu_arvalid = 1'b1;
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        wait_rv(1, 20, cyc);
        lsu_arvalid = 1'b0;
        ar_dly = 0;
        settle(5);
        chk("dropped_req_ignored", mem_arvalid, 0);

        // both requesting continuously for four transactions
        do_reset();
        la  = 32'h8000_2000;
        ia  = 32'h8000_0200;
        fav = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef YSYX_MEM_ARB_RR_EN
            own = fav;
            fav = ~own;
`else
            own = 1'b1;
`endif
            if (own) begin expect_rd(1, la); la += 32'd4; end
            else begin expect_rd(0, ia); ia += 32'd4; end
        end
        lsu_araddr  = 32'h8000_2000;
        ifu_araddr  = 32'h8000_0200;
        lsu_arvalid = 1'b1;
        ifu_arvalid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            wl  = 1'b0;
            cyc = 0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                got = ifu_rvalid || lsu_rvalid;
                wl  = lsu_rvalid;
            end
            if (!got) chk("stream_timeout", got, 1);
            @(posedge clk); #1;
            if (wl) lsu_araddr += 32'd4;
            else    ifu_araddr += 32'd4;
            if (t == 3) begin
                lsu_arvalid = 1'b0;
                ifu_arvalid = 1'b0;
            end
        end
        settle(3);

        // reset in DATA, then a late beat from memory
        r_dly = 20;
        ifu_araddr = 32'h8000_0300;
        expect_rd(0, 32'h8000_0300);
        ifu_arvalid = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = mem_rready;
        end
        if (!got) chk("reach_data_timeout", got, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        ifu_arvalid = 1'b0;
        @(negedge clk);
        chk("midrst_ctl", {mem_arvalid, mem_rready, ifu_rvalid, lsu_rvalid, ifu_rerr, lsu_rerr}, 0);
        chk("midrst_bus", {mem_araddr, ifu_rdata}, 0);
        sb.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        r_dly = 0;
        chk("post_rst_idle", {mem_arvalid, mem_rready}, 0);
        settle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
